// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled 3-sample majority vote, optional parity, 1/2 stop bits,
// valid/ready output with overrun. Define UART_RX_BREAK_DET_EN to enable line-break detection.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           parity_type,
    input  logic                 stop_bits,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 active_flag,
    output logic [2:0]           error_flag,
    output logic                 break_flag
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0]  SAMP_A    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SAMP_B    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SAMP_C    = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_prev_reg;
    logic                   rx_s;

    logic [2:0]           state_reg,    state_next;
    logic [DIV_WIDTH-1:0] tick_cnt_reg, tick_cnt_next;
    logic [OS_W-1:0]      os_cnt_reg,   os_cnt_next;
    logic [DIV_WIDTH-1:0] div_reg,      div_next;
    logic [1:0]           par_reg,      par_next;
    logic                 stop2_reg,    stop2_next;
    logic [1:0]           samp_reg,     samp_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic [BIT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
    logic                 par_err_reg,  par_err_next;
    logic                 frm_err_reg,  frm_err_next;
    logic                 zero_reg,     zero_next;
    logic                 done_reg,     done_next;
    logic                 active_reg,   active_next;

    logic [DATA_BITS-1:0] dout_reg;
    logic                 valid_reg;
    logic [2:0]           err_reg;
    logic                 brk_reg;

    logic [DIV_WIDTH-1:0] div_eff;
    logic                 tick;
    logic                 decide;
    logic                 maj;
    logic                 armed;
    logic                 start_det;
    logic                 brk_det;

`ifdef UART_RX_BREAK_DET_EN
    logic wait_high_reg, wait_high_next;
    assign armed   = ~wait_high_reg;
    assign brk_det = zero_reg;
`else
    assign armed   = 1'b1;
    assign brk_det = 1'b0;
`endif

    assign rx_s      = sync_reg[SYNC_STAGES-1];
    // The live divisor only matters while idle; a frame runs on the value captured at its start.
    assign div_eff   = (state_reg == S_IDLE) ? baud_div : div_reg;
    assign tick      = (tick_cnt_reg == div_eff);
    assign decide    = tick && (os_cnt_reg == SAMP_C);
    assign maj       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
    assign start_det = (state_reg == S_IDLE) && armed && rx_prev_reg && !rx_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx_in};
            rx_prev_reg <= rx_s;
        end
    end

    always_comb begin
        state_next    = state_reg;
        os_cnt_next   = os_cnt_reg;
        div_next      = div_reg;
        par_next      = par_reg;
        stop2_next    = stop2_reg;
        samp_next     = samp_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        par_err_next  = par_err_reg;
        frm_err_next  = frm_err_reg;
        zero_next     = zero_reg;
        done_next     = 1'b0;
        active_next   = active_reg;
`ifdef UART_RX_BREAK_DET_EN
        wait_high_next = wait_high_reg;
        if (rx_s)
            wait_high_next = 1'b0;
`endif
        tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
        if (tick)
            os_cnt_next = (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + 1'b1;
        if (tick && os_cnt_reg == SAMP_A)
            samp_next[0] = rx_s;
        if (tick && os_cnt_reg == SAMP_B)
            samp_next[1] = rx_s;
        if (done_reg)
            active_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start_det) begin
                    state_next    = S_START;
                    tick_cnt_next = '0;
                    os_cnt_next   = '0;
                    div_next      = baud_div;
                    par_next      = parity_type;
                    stop2_next    = stop_bits;
                    bit_cnt_next  = '0;
                    par_err_next  = 1'b0;
                    frm_err_next  = 1'b0;
                    zero_next     = 1'b1;
                    active_next   = 1'b1;
                end
            end
            S_START: begin
                if (decide) begin
                    if (maj) begin
                        state_next  = S_IDLE;
                        active_next = 1'b0;
                    end else begin
                        state_next  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_next   = {maj, shift_reg[DATA_BITS-1:1]};
                    zero_next    = zero_reg & ~maj;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BIT_LAST)
                        state_next = (par_reg == 2'b01 || par_reg == 2'b10) ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (decide) begin
                    // par_reg[0] is 1 for odd, 0 for even: the required value of data^parity.
                    par_err_next = ((^shift_reg) ^ maj) != par_reg[0];
                    zero_next    = zero_reg & ~maj;
                    state_next   = S_STOP1;
                end
            end
            S_STOP1, S_STOP2: begin
                if (decide) begin
                    if (!maj)
                        frm_err_next = 1'b1;
                    zero_next = zero_reg & ~maj;
                    if (state_reg == S_STOP1 && stop2_reg) begin
                        state_next = S_STOP2;
                    end else begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        wait_high_next = zero_reg & ~maj;
`endif
                    end
                end
            end
            default: begin
                state_next  = S_IDLE;
                active_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            tick_cnt_reg <= '0;
            os_cnt_reg   <= '0;
            div_reg      <= '0;
            par_reg      <= 2'b00;
            stop2_reg    <= 1'b0;
            samp_reg     <= 2'b11;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            par_err_reg  <= 1'b0;
            frm_err_reg  <= 1'b0;
            zero_reg     <= 1'b0;
            done_reg     <= 1'b0;
            active_reg   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            wait_high_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            os_cnt_reg   <= os_cnt_next;
            div_reg      <= div_next;
            par_reg      <= par_next;
            stop2_reg    <= stop2_next;
            samp_reg     <= samp_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            par_err_reg  <= par_err_next;
            frm_err_reg  <= frm_err_next;
            zero_reg     <= zero_next;
            done_reg     <= done_next;
            active_reg   <= active_next;
`ifdef UART_RX_BREAK_DET_EN
            wait_high_reg <= wait_high_next;
`endif
        end
    end

    // An all-zero frame reports framing only, whatever the parity bit made of it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 3'b000;
            brk_reg   <= 1'b0;
        end else if (done_reg) begin
            if (valid_reg && !data_ready) begin
                err_reg[2] <= 1'b1;
            end else begin
                dout_reg  <= shift_reg;
                valid_reg <= 1'b1;
                err_reg   <= zero_reg ? 3'b010 : {1'b0, frm_err_reg, par_err_reg};
                brk_reg   <= brk_det;
            end
        end else if (valid_reg && data_ready) begin
            valid_reg <= 1'b0;
            brk_reg   <= 1'b0;
        end
    end

    assign data_out    = dout_reg;
    assign data_valid  = valid_reg;
    assign error_flag  = err_reg;
    assign break_flag  = brk_reg;
    assign active_flag = active_reg;

endmodule
